dynamic_noise_gate: RTL and testbench
=====================================

# dynamic_noise_gate

Hysteretic noise gate with a peak-envelope detector, hold timer, and linear attack/release gain ramps. It is the first effect stage of the pedalboard chain: it takes the design-under-test output (or the raw ADC sample) and feeds the chorus input. Gating is decided once per audio sample, on `sample_tick_i`. The gain change is ramped so that opening and closing the gate does not click.

## Interface

Parameters:
- `DWIDTH`, 16: sample width, signed two's complement.
- `THRESHOLD`, 16'h0200: envelope level that opens the gate (unsigned, DWIDTH bits).
- `HYSTERESIS`, 16'h0080: the close level is `THRESHOLD - HYSTERESIS`. Must be less than `THRESHOLD`.
- `HOLD_SAMPLES`, 2400: number of sample ticks to wait below the close level before releasing. Must be at least 1.
- `ENV_SHIFT`, 6: envelope decay per tick is `env >> ENV_SHIFT`.
- `ATTACK_STEP`, 32: gain increment per tick in ATTACK.
- `RELEASE_STEP`, 1: gain decrement per tick in RELEASE.

Ports:
- `clk_i`, in, 1: system clock.
- `srst_i`, in, 1: asynchronous, active-high reset.
- `sample_tick_i`, in, 1: one-cycle strobe marking a new sample. Consecutive strobes are at least 3 cycles apart.
- `enable_i`, in, 1: 1 = gate active, 0 = bypass.
- `data_i`, in, DWIDTH: signed input sample, valid while `sample_tick_i` is high.
- `data_o`, out, DWIDTH: signed gated sample, registered and held between updates.
- `gate_open_o`, out, 1: 1 when the FSM state is not CLOSED.

## Operation

- Reset values:
  - `data_o` = 0, `gate_open_o` = 0.
  - Envelope `env` = 0, state = CLOSED, `gain` = 0, hold counter = 0.
- Absolute value:
  - `abs = |data_i|`.
  - The most negative input (-2^(DWIDTH-1)) saturates to 2^(DWIDTH-1)-1.
- Envelope update, on each tick:
  - If `abs > env`, then `env <= abs`.
  - Otherwise `env <= env - (env >> ENV_SHIFT)`.
  - `env` is unsigned, DWIDTH-1 bits, and cannot underflow.
- `gain` is unsigned 9 bits, range 0..256; 256 is unity.
- FSM states are CLOSED, ATTACK, OPEN, HOLD, RELEASE. The FSM is evaluated once per tick, using the just-updated `env`:
  - **CLOSED**: `gain` = 0. If `env >= THRESHOLD`, go to ATTACK.
  - **ATTACK**: `gain <= min(gain + ATTACK_STEP, 256)`. When the new gain is 256, go to OPEN. The close level is ignored in this state.
  - **OPEN**: `gain` = 256. If `env < THRESHOLD - HYSTERESIS`, go to HOLD and load the hold counter with `HOLD_SAMPLES - 1`.
  - **HOLD**: `gain` = 256.
    - If `env >= THRESHOLD`, go to OPEN.
    - Else if the counter is 0, go to RELEASE.
    - Else decrement the counter.
  - **RELEASE**: `gain <= max(gain - RELEASE_STEP, 0)`.
    - If `env >= THRESHOLD`, go to ATTACK instead, keeping the current gain (the ramp continues up from there).
    - When the new gain is 0, go to CLOSED.
- Output arithmetic:
  - `data_o = (sample * gain) >>> 8`.
  - The product is DWIDTH+10 bits, signed × zero-extended gain.
  - The shift is arithmetic, so the result truncates toward minus infinity.
  - The result always fits DWIDTH bits. Gain 256 reproduces the sample exactly.
- Bypass:
  - While `enable_i` = 0, on each tick the FSM is forced to OPEN, `gain` to 256, and the hold counter to 0. `env` keeps tracking.
  - `data_o` therefore equals the input sample, with the same latency as the active path.
  - When `enable_i` rises, the gate starts from OPEN.
- Between ticks, all state and `data_o` hold their values.

## Timing

- Cycle T (`sample_tick_i` = 1): `data_i` is captured and `env` is updated.
- Cycle T+1: the FSM, `gain` and hold counter are updated, and `gate_open_o` takes its new value.
- Cycle T+2: `data_o` = captured sample × new gain >>> 8.
- Latency from tick to `data_o` is 2 clocks. Throughput is one sample per tick.
- Asynchronous reset asserted at any point (including mid-ramp or mid-hold) clears every register immediately. The first tick after release starts from CLOSED.
- A tick arriving during the T+1/T+2 pipeline violates the minimum strobe spacing. Behaviour in that case is undefined and is checked by a bench assertion.

## Test plan

1. **Reset.** Assert `srst_i` asynchronously with no clock edge, then drive ticks with `data_i` = 0.
   - Expect `data_o` = 0 and `gate_open_o` = 0 immediately on assertion.
   - Expect both to stay 0 and the state to stay CLOSED.
2. **Attack ramp.** With defaults, drive a constant `data_i` = 16'h1000.
   - On tick 1, `gate_open_o` rises and `data_o` = 16'h0200.
   - On tick k (k = 1..8), `data_o` = 16'h0200·k, reaching 16'h1000 on tick 8 (state OPEN).
3. **Hold and release.** From OPEN, switch `data_i` to 16'h0010.
   - `env` decays from 16'h1000 until it drops below 16'h0180. `data_o` stays 16'h0010 through that decay and for 2400 further ticks.
   - Then `data_o` ramps down over 256 ticks (gain 255→0, following 16'h0010·gain>>8) and reaches 0.
   - `gate_open_o` falls at T+1 of the tick where gain reaches 0.
4. **Retrigger.**
   - During HOLD, restoring 16'h1000 returns the FSM to OPEN with no gain dip, and the hold counter restarts on the next close.
   - During RELEASE at gain 100, restoring 16'h1000 gives gains 132, 164, …, 256.
5. **Extremes.** Drive `data_i` = 16'h8000 while OPEN.
   - `env` = 16'h7FFF.
   - `data_o` = 16'h8000 exactly; with gain 128 the expected value is 16'hC000.
6. **Bypass.** Drop `enable_i` mid-RELEASE.
   - From the next tick, `data_o` equals `data_i` with 2-clock latency.
   - Re-enabling gives OPEN; silence then leads through HOLD → RELEASE → CLOSED as in scenario 3.

Source files
------------

// File: rtl/dynamic_noise_gate.sv
// Hysteretic noise gate: peak envelope, hold timer, linear attack/release gain.
// Ports: clk_i, srst_i (async high), sample_tick_i, enable_i, data_i -> data_o, gate_open_o.
module dynamic_noise_gate #(
    parameter int unsigned        DWIDTH       = 16,
    parameter logic [DWIDTH-1:0]  THRESHOLD    = 16'h0200,
    parameter logic [DWIDTH-1:0]  HYSTERESIS   = 16'h0080,
    parameter int unsigned        HOLD_SAMPLES = 2400,
    parameter int unsigned        ENV_SHIFT    = 6,
    parameter int unsigned        ATTACK_STEP  = 32,
    parameter int unsigned        RELEASE_STEP = 1
) (
    input  logic                     clk_i,
    input  logic                     srst_i,
    input  logic                     sample_tick_i,
    input  logic                     enable_i,
    input  logic signed [DWIDTH-1:0] data_i,
    output logic signed [DWIDTH-1:0] data_o,
    output logic                     gate_open_o
);

    localparam int unsigned EW = DWIDTH - 1;
    localparam int unsigned HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [DWIDTH-1:0] CLOSE_LVL  = THRESHOLD - HYSTERESIS;
    localparam logic [8:0]        GAIN_UNITY = 9'd256;
    localparam logic [9:0]        ATK        = 10'(ATTACK_STEP);
    localparam logic [8:0]        REL        = 9'(RELEASE_STEP);
    localparam logic [8:0]        GAIN_FIRST =
        (ATTACK_STEP >= 256) ? GAIN_UNITY : 9'(ATTACK_STEP);
    localparam logic [HW-1:0]     HOLD_LOAD  = HW'(HOLD_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_ATTACK,
        ST_OPEN,
        ST_HOLD,
        ST_RELEASE
    } state_t;

    // Stage 0 (tick cycle): sample, enable and envelope capture
    logic [DWIDTH-1:0] smp_q, smp_d;
    logic              en_q, en_d;
    logic [EW-1:0]     env_q, env_d;
    logic              upd_q, upd_d;
    // Stage 1: FSM / gain / hold counter
    state_t            state_q, state_d;
    logic [8:0]        gain_q, gain_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              gate_q, gate_d;
    logic              out_q, out_d;
    // Stage 2: scaled output
    logic [DWIDTH-1:0] dout_q, dout_d;

    logic [DWIDTH-1:0]        neg;
    logic [EW-1:0]            abs_v;
    logic [EW-1:0]            env_dec;
    logic                     env_ge_thr;
    logic                     env_lt_close;
    logic [9:0]               gain_up;
    logic [8:0]               gain_sat;
    logic [8:0]               gain_dn;
    logic signed [DWIDTH+9:0] prod;

    // |data_i| in DWIDTH-1 bits; the most negative code saturates to all ones
    always_comb begin
        neg = -data_i;
        if (!data_i[DWIDTH-1]) begin
            abs_v = EW'(data_i);
        end else if (data_i[DWIDTH-2:0] == '0) begin
            abs_v = '1;
        end else begin
            abs_v = EW'(neg);
        end
    end

    always_comb begin
        env_dec = env_q - (env_q >> ENV_SHIFT);
        smp_d   = smp_q;
        en_d    = en_q;
        env_d   = env_q;
        upd_d   = sample_tick_i;
        if (sample_tick_i) begin
            smp_d = data_i;
            en_d  = enable_i;
            env_d = (abs_v > env_q) ? abs_v : env_dec;
        end
    end

    always_comb begin
        env_ge_thr   = {1'b0, env_q} >= THRESHOLD;
        env_lt_close = {1'b0, env_q} < CLOSE_LVL;
        gain_up      = {1'b0, gain_q} + ATK;
        gain_sat     = (gain_up >= 10'd256) ? GAIN_UNITY : gain_up[8:0];
        gain_dn      = (gain_q <= REL) ? 9'd0 : gain_q - REL;
    end

    // Gain state machine, evaluated the cycle after a tick so it sees the
    // freshly updated envelope
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        hold_d  = hold_q;
        out_d   = upd_q;
        if (upd_q) begin
            if (!en_q) begin
                state_d = ST_OPEN;
                gain_d  = GAIN_UNITY;
                hold_d  = '0;
            end else begin
                unique case (state_q)
                    ST_CLOSED: begin
                        gain_d = 9'd0;
                        if (env_ge_thr) begin
                            // first attack step lands on the opening tick
                            gain_d  = GAIN_FIRST;
                            state_d = (GAIN_FIRST == GAIN_UNITY) ?
                                      ST_OPEN : ST_ATTACK;
                        end
                    end
                    ST_ATTACK: begin
                        gain_d = gain_sat;
                        if (gain_sat == GAIN_UNITY) begin
                            state_d = ST_OPEN;
                        end
                    end
                    ST_OPEN: begin
                        gain_d = GAIN_UNITY;
                        if (env_lt_close) begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_LOAD;
                        end
                    end
                    ST_HOLD: begin
                        gain_d = GAIN_UNITY;
                        if (env_ge_thr) begin
                            state_d = ST_OPEN;
                        end else if (hold_q == '0) begin
                            state_d = ST_RELEASE;
                        end else begin
                            hold_d = hold_q - HW'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (env_ge_thr) begin
                            // ramp back up from the current gain
                            state_d = ST_ATTACK;
                        end else begin
                            gain_d = gain_dn;
                            if (gain_dn == 9'd0) begin
                                state_d = ST_CLOSED;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_CLOSED;
                        gain_d  = 9'd0;
                        hold_d  = '0;
                    end
                endcase
            end
        end
        gate_d = (state_d != ST_CLOSED);
    end

    // Signed sample times zero-extended gain; arithmetic shift floors
    always_comb begin
        prod   = $signed(smp_q) * $signed({1'b0, gain_q});
        dout_d = out_q ? DWIDTH'(prod >>> 8) : dout_q;
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            smp_q   <= '0;
            en_q    <= 1'b0;
            env_q   <= '0;
            upd_q   <= 1'b0;
            state_q <= ST_CLOSED;
            gain_q  <= 9'd0;
            hold_q  <= '0;
            gate_q  <= 1'b0;
            out_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            smp_q   <= smp_d;
            en_q    <= en_d;
            env_q   <= env_d;
            upd_q   <= upd_d;
            state_q <= state_d;
            gain_q  <= gain_d;
            hold_q  <= hold_d;
            gate_q  <= gate_d;
            out_q   <= out_d;
            dout_q  <= dout_d;
        end
    end

    assign data_o      = dout_q;
    assign gate_open_o = gate_q;

endmodule

// File: tb/tb_dynamic_noise_gate.sv
// Scoreboarded directed bench for dynamic_noise_gate.
// A spec-level model queues expected gate/data per tick; checks run at T+1/T+2.
module tb_dynamic_noise_gate;

    localparam int THR  = 512;
    localparam int HYS  = 128;
    localparam int HOLD = 2400;
    localparam int ATKS = 32;

    localparam int S_CLOSED  = 0;
    localparam int S_ATTACK  = 1;
    localparam int S_OPEN    = 2;
    localparam int S_HOLD    = 3;
    localparam int S_RELEASE = 4;

    logic               clk = 1'b0;
    logic               srst;
    logic               tick;
    logic               en;
    logic signed [15:0] din;
    logic signed [15:0] dout;
    logic               gate;

    typedef struct {
        logic [15:0] data;
        logic        gate;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    int m_env, m_gain, m_hold, m_st;

    logic t1 = 1'b0;
    logic t2 = 1'b0;

    dynamic_noise_gate dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .sample_tick_i(tick),
        .enable_i     (en),
        .data_i       (din),
        .data_o       (dout),
        .gate_open_o  (gate)
    );

    always #5 clk = ~clk;

    // minimum strobe spacing guard
    always @(posedge clk) begin
        t1 <= tick;
        t2 <= t1;
        assert (!(tick && (t1 || t2))) else begin
            n_err++;
            $error("FAIL tick_spacing observed=1 expected=0");
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_env  = 0;
        m_gain = 0;
        m_hold = 0;
        m_st   = S_CLOSED;
    endtask

    task automatic model_step(input logic signed [15:0] d, input logic e,
                              output logic [15:0] y, output logic g);
        int s, a, p;
        s = int'(d);
        a = (s == -32768) ? 32767 : ((s < 0) ? -s : s);
        if (a > m_env) m_env = a;
        else m_env = m_env - (m_env >> 6);
        if (!e) begin
            m_st   = S_OPEN;
            m_gain = 256;
            m_hold = 0;
        end else begin
            case (m_st)
                S_CLOSED: begin
                    if (m_env >= THR) begin
                        m_gain = (ATKS >= 256) ? 256 : ATKS;
                        m_st   = (m_gain == 256) ? S_OPEN : S_ATTACK;
                    end else begin
                        m_gain = 0;
                    end
                end
                S_ATTACK: begin
                    m_gain = m_gain + ATKS;
                    if (m_gain >= 256) begin
                        m_gain = 256;
                        m_st   = S_OPEN;
                    end
                end
                S_OPEN: begin
                    if (m_env < THR - HYS) begin
                        m_st   = S_HOLD;
                        m_hold = HOLD - 1;
                    end
                end
                S_HOLD: begin
                    if (m_env >= THR) m_st = S_OPEN;
                    else if (m_hold == 0) m_st = S_RELEASE;
                    else m_hold = m_hold - 1;
                end
                default: begin
                    if (m_env >= THR) begin
                        m_st = S_ATTACK;
                    end else begin
                        m_gain = m_gain - 1;
                        if (m_gain <= 0) begin
                            m_gain = 0;
                            m_st   = S_CLOSED;
                        end
                    end
                end
            endcase
        end
        p = s * m_gain;
        y = 16'(p >>> 8);
        g = (m_st != S_CLOSED);
    endtask

    // Called at a negedge; returns at the negedge after the T+2 edge.
    task automatic do_tick(input logic signed [15:0] d, input logic e,
                           output logic [15:0] got);
        exp_t        x;
        exp_t        y;
        logic [15:0] prev;
        prev = dout;
        din  = d;
        en   = e;
        tick = 1'b1;
        model_step(d, e, x.data, x.gate);
        sb.push_back(x);
        @(negedge clk);
        tick = 1'b0;
        din  = 16'($urandom);
        @(negedge clk);
        y = sb.pop_front();
        check("gate_open", {15'd0, gate}, {15'd0, y.gate});
        check("data_held", dout, prev);
        @(negedge clk);
        check("data_out", dout, y.data);
        got = dout;
    endtask

    function automatic bit cond_met(input int sel, input int gval);
        case (sel)
            0:       return m_st == S_CLOSED;
            1:       return (m_st == S_HOLD) && (m_hold < 2000);
            default: return (m_st == S_RELEASE) && (m_gain == gval);
        endcase
    endfunction

    task automatic silence_until(input int sel, input int gval,
                                 input string tag);
        logic [15:0] got;
        int          n;
        n = 0;
        while (!cond_met(sel, gval) && n < 6000) begin
            do_tick(16'sh0010, 1'b1, got);
            n++;
        end
        n_vec++;
        assert (cond_met(sel, gval)) else begin
            n_err++;
            $error("FAIL %s observed=timeout expected=reached", tag);
        end
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] d;
        int          g;

        srst = 1'b1;
        tick = 1'b0;
        en   = 1'b1;
        din  = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_data", dout, 16'h0000);
        check("rst_gate", {15'd0, gate}, 16'h0000);
        srst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            do_tick(16'sh0000, 1'b1, got);
        end
        check("closed_gate", {15'd0, gate}, 16'h0000);

        // partial ramp, then asynchronous reset between edges
        for (int k = 1; k <= 4; k++) begin
            do_tick(16'sh1000, 1'b1, got);
        end
        #2 srst = 1'b1;
        #1;
        check("async_rst_data", dout, 16'h0000);
        check("async_rst_gate", {15'd0, gate}, 16'h0000);
        model_reset();
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);

        // attack ramp
        for (int k = 1; k <= 8; k++) begin
            do_tick(16'sh1000, 1'b1, got);
            check("attack_ramp", got, 16'(32'h200 * k));
        end

        // hold then release to closed
        silence_until(0, 0, "release_to_closed");
        check("closed_data", dout, 16'h0000);
        check("closed_gate2", {15'd0, gate}, 16'h0000);

        // retrigger during hold
        for (int k = 1; k <= 8; k++) begin
            do_tick(16'sh1000, 1'b1, got);
        end
        silence_until(1, 0, "reach_hold");
        do_tick(16'sh1000, 1'b1, got);
        check("hold_retrigger", got, 16'h1000);

        // retrigger during release at gain 100
        silence_until(2, 100, "reach_gain100");
        do_tick(16'sh1000, 1'b1, got);
        check("rel_retrig_100", got, 16'h0640);
        g = 100;
        for (int k = 0; k < 5; k++) begin
            g = (g + 32 > 256) ? 256 : g + 32;
            do_tick(16'sh1000, 1'b1, got);
            check("rel_retrig_ramp", got, 16'(16 * g));
        end

        // most negative input at gain 128, then at unity
        silence_until(2, 128, "reach_gain128");
        do_tick(16'sh8000, 1'b1, got);
        check("neg_full_g128", got, 16'hC000);
        for (int k = 0; k < 5; k++) begin
            do_tick(16'sh8000, 1'b1, got);
        end
        check("neg_full_unity", got, 16'h8000);

        // bypass mid-release
        silence_until(2, 200, "reach_gain200");
        for (int k = 0; k < 8; k++) begin
            d = 16'($urandom);
            do_tick(d, 1'b0, got);
            check("bypass", got, d);
        end
        do_tick(16'sh0010, 1'b1, got);
        check("reenable_gate", {15'd0, gate}, 16'h0001);
        silence_until(0, 0, "reenable_close");
        check("final_gate", {15'd0, gate}, 16'h0000);
        check("final_data", dout, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
